// File: rtl/ps2_key_action_router.sv
// PS/2 scan-code decoder that maps make/break (optionally E0-extended) codes onto a
// configurable set of game actions: press pulses, held levels and optional auto-repeat.
module ps2_key_action_router #(
    parameter int unsigned               NUM_ACTIONS    = 6,
    parameter logic [NUM_ACTIONS*9-1:0]  KEYMAP         = {9'h02D, 9'h029, 9'h172,
                                                           9'h175, 9'h174, 9'h16B},
    parameter bit                        REPEAT_EN      = 1'b0,
    parameter int unsigned               REPEAT_DELAY   = 25000000,
    parameter int unsigned               REPEAT_PERIOD  = 5000000,
    parameter int unsigned               PREFIX_TIMEOUT = 2500000
) (
    input  logic                   topIN_clk_50,
    input  logic                   wire_reset,
    input  logic [7:0]             scan_code,
    input  logic                   scan_code_ready,
    output logic [NUM_ACTIONS-1:0] action_pulse,
    output logic [NUM_ACTIONS-1:0] action_held,
    output logic                   unknown_pulse,
    output logic                   seq_error,
    output logic [8:0]             last_code
);

    localparam int unsigned MAX_A   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned MAX_CNT = (MAX_A > PREFIX_TIMEOUT) ? MAX_A : PREFIX_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned IDX_W   = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(PREFIX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RPT_DELAY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_PER   = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic [NUM_ACTIONS-1:0] pulse_q, pulse_d;
    logic [NUM_ACTIONS-1:0] held_q, held_d;
    logic                   unknown_q, unknown_d;
    logic                   seq_err_q, seq_err_d;
    logic [8:0]             last_q, last_d;
    logic                   rpt_on_q, rpt_on_d;
    logic [IDX_W-1:0]       rpt_idx_q, rpt_idx_d;
    logic [CNT_W-1:0]       rpt_cnt_q, rpt_cnt_d;

    logic                   do_make, do_break, ev_ext, is_prefix, found;
    logic [8:0]             ev_code;
    logic [NUM_ACTIONS-1:0] match;

    always_ff @(posedge topIN_clk_50 or posedge wire_reset) begin
        if (wire_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: prefix decoding and the prefix timeout, which clears on every strobe.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        do_make   = 1'b0;
        do_break  = 1'b0;
        ev_ext    = 1'b0;
        seq_err_d = 1'b0;
        is_prefix = (scan_code == 8'hE0) || (scan_code == 8'hF0);
        if (scan_code_ready) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (scan_code == 8'hE0)      state_d = GOT_E0;
                    else if (scan_code == 8'hF0) state_d = GOT_F0;
                    else                         do_make = 1'b1;
                end
                GOT_E0: begin
                    if (scan_code == 8'hF0) begin
                        state_d = GOT_E0F0;
                    end else if (scan_code == 8'hE0) begin
                        seq_err_d = 1'b1;
                    end else begin
                        do_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                GOT_F0: begin
                    state_d   = IDLE;
                    seq_err_d = is_prefix;
                    do_break  = !is_prefix;
                end
                GOT_E0F0: begin
                    state_d   = IDLE;
                    seq_err_d = is_prefix;
                    do_break  = !is_prefix;
                    ev_ext    = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d   = IDLE;
                tmo_d     = '0;
                seq_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + CNT_ONE;
            end
        end
    end

    // Outputs: keymap lookup, held/pulse update and the auto-repeat timer.
    always_comb begin
        ev_code   = {ev_ext, scan_code};
        held_d    = held_q;
        pulse_d   = '0;
        unknown_d = 1'b0;
        last_d    = last_q;
        rpt_on_d  = rpt_on_q;
        rpt_idx_d = rpt_idx_q;
        rpt_cnt_d = rpt_cnt_q;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_ACTIONS; i++) begin
            match[i] = (KEYMAP[9*i +: 9] == ev_code);
        end
        if (do_make) begin
            last_d    = ev_code;
            pulse_d   = match & ~held_q;
            held_d    = held_q | match;
            unknown_d = (match == '0);
        end
        if (do_break) begin
            last_d = ev_code;
            held_d = held_q & ~match;
        end
        if (REPEAT_EN) begin
            // A fresh press takes priority over a repeat expiry in the same cycle.
            if (pulse_d != '0) begin
                rpt_on_d  = 1'b1;
                rpt_cnt_d = RPT_DELAY;
                for (int unsigned i = 0; i < NUM_ACTIONS; i++) begin
                    if (pulse_d[i] && !found) begin
                        rpt_idx_d = IDX_W'(i);
                        found     = 1'b1;
                    end
                end
            end else if (rpt_on_q && !held_d[rpt_idx_q]) begin
                rpt_on_d  = 1'b0;
                rpt_cnt_d = '0;
            end else if (rpt_on_q) begin
                if (rpt_cnt_q <= CNT_ONE) begin
                    pulse_d[rpt_idx_q] = 1'b1;
                    rpt_cnt_d          = RPT_PER;
                end else begin
                    rpt_cnt_d = rpt_cnt_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge topIN_clk_50 or posedge wire_reset) begin
        if (wire_reset) begin
            tmo_q     <= '0;
            pulse_q   <= '0;
            held_q    <= '0;
            unknown_q <= 1'b0;
            seq_err_q <= 1'b0;
            last_q    <= '0;
            rpt_on_q  <= 1'b0;
            rpt_idx_q <= '0;
            rpt_cnt_q <= '0;
        end else begin
            tmo_q     <= tmo_d;
            pulse_q   <= pulse_d;
            held_q    <= held_d;
            unknown_q <= unknown_d;
            seq_err_q <= seq_err_d;
            last_q    <= last_d;
            rpt_on_q  <= rpt_on_d;
            rpt_idx_q <= rpt_idx_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign action_pulse  = pulse_q;
    assign action_held   = held_q;
    assign unknown_pulse = unknown_q;
    assign seq_error     = seq_err_q;
    assign last_code     = last_q;

endmodule

// File: tb/tb_ps2_key_action_router.sv
// Directed bench for ps2_key_action_router with an event-level reference model checked every cycle.
module tb_ps2_key_action_router;

    localparam int unsigned NA  = 6;
    localparam int unsigned DLY = 10;
    localparam int unsigned PER = 4;
    localparam int unsigned PT  = 12;
    localparam logic [NA*9-1:0] KM = {9'h02D, 9'h029, 9'h172, 9'h175, 9'h174, 9'h16B};

    logic          clk = 1'b0;
    logic          wire_reset;
    logic [7:0]    scan_code;
    logic          scan_code_ready;
    logic [NA-1:0] action_pulse, action_held;
    logic          unknown_pulse, seq_error;
    logic [8:0]    last_code;

    ps2_key_action_router #(
        .NUM_ACTIONS(NA), .KEYMAP(KM), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .PREFIX_TIMEOUT(PT)
    ) u_dut (
        .topIN_clk_50(clk), .wire_reset(wire_reset), .scan_code(scan_code),
        .scan_code_ready(scan_code_ready), .action_pulse(action_pulse),
        .action_held(action_held), .unknown_pulse(unknown_pulse),
        .seq_error(seq_error), .last_code(last_code)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: pending-prefix flags, key table and absolute-step repeat schedule.
    logic [8:0]    km [NA] = '{9'h16B, 9'h174, 9'h175, 9'h172, 9'h029, 9'h02D};
    bit            m_ext, m_brk, r_on, matched;
    int unsigned   step = 0, last_strobe = 0, r_next = 0;
    int            r_idx = 0;
    logic [NA-1:0] m_pulse = '0, m_held = '0, n_pulse;
    logic          m_unk = 1'b0, m_err = 1'b0, n_unk, n_err;
    logic [8:0]    m_last = '0, ev;

    always @(negedge clk) begin
        if (wire_reset) begin
            m_ext = 0; m_brk = 0; r_on = 0;
            m_pulse = '0; m_held = '0; m_unk = 0; m_err = 0; m_last = '0;
        end
        chk("pulse", 32'(action_pulse), 32'(m_pulse));
        chk("held", 32'(action_held), 32'(m_held));
        chk("unknown", 32'(unknown_pulse), 32'(m_unk));
        chk("seq_error", 32'(seq_error), 32'(m_err));
        chk("last_code", 32'(last_code), 32'(m_last));
        if (!wire_reset) begin
            n_pulse = '0; n_unk = 0; n_err = 0;
            if (scan_code_ready) begin
                last_strobe = step;
                if (scan_code == 8'hE0) begin
                    if (m_brk) begin n_err = 1; m_ext = 0; m_brk = 0; end
                    else if (m_ext) n_err = 1;
                    else m_ext = 1;
                end else if (scan_code == 8'hF0) begin
                    if (m_brk) begin n_err = 1; m_ext = 0; m_brk = 0; end
                    else m_brk = 1;
                end else begin
                    ev = {m_ext, scan_code};
                    m_last = ev;
                    matched = 0;
                    for (int i = 0; i < NA; i++) begin
                        if (km[i] == ev) begin
                            matched = 1;
                            if (m_brk) m_held[i] = 1'b0;
                            else if (!m_held[i]) begin m_held[i] = 1'b1; n_pulse[i] = 1'b1; end
                        end
                    end
                    if (!m_brk && !matched) n_unk = 1;
                    m_ext = 0; m_brk = 0;
                end
            end else if ((m_ext || m_brk) && (step - last_strobe == PT)) begin
                n_err = 1; m_ext = 0; m_brk = 0;
            end
            if (n_pulse != '0) begin
                r_on = 1; r_next = step + DLY;
                for (int i = NA - 1; i >= 0; i--) if (n_pulse[i]) r_idx = i;
            end else if (r_on && !m_held[r_idx]) begin
                r_on = 0;
            end else if (r_on && step == r_next) begin
                n_pulse[r_idx] = 1'b1;
                r_next = r_next + PER;
            end
            m_pulse = n_pulse; m_unk = n_unk; m_err = n_err;
        end
        step++;
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        scan_code = b; scan_code_ready = 1'b1;
        @(posedge clk); #1;
        scan_code_ready = 1'b0;
    endtask

    task automatic reset_dut();
        wire_reset = 1'b1; idle(2); wire_reset = 1'b0;
    endtask

    logic [7:0]  seq2 [9] = '{8'hE0, 8'h6B, 8'hE0, 8'h6B, 8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B};
    int unsigned p0cnt;
    logic [31:0] mask;

    initial begin
        wire_reset = 1'b1; scan_code_ready = 1'b0; scan_code = 8'h00;
        idle(2);
        chk("rst_held", 32'(action_held), 32'h0);
        chk("rst_last", 32'(last_code), 32'h0);
        wire_reset = 1'b0;
        idle(1);

        send(8'hE0);
        chk("t1_no_early_pulse", 32'(action_pulse), 32'h0);
        send(8'h6B);
        chk("t1_pulse", 32'(action_pulse), 32'h01);
        chk("t1_held", 32'(action_held), 32'h01);
        chk("t1_last", 32'(last_code), 32'h16B);
        idle(1);
        chk("t1_pulse_1cyc", 32'(action_pulse), 32'h0);
        chk("t1_held_stays", 32'(action_held), 32'h01);
        reset_dut();

        p0cnt = 0;
        for (int i = 0; i < 9; i++) begin
            send(seq2[i]);
            p0cnt += 32'(action_pulse[0]);
        end
        chk("t2_held_drop", 32'(action_held[0]), 32'h0);
        idle(1);
        p0cnt += 32'(action_pulse[0]);
        chk("t2_one_pulse", p0cnt, 32'd1);
        reset_dut();

        send(8'h29); send(8'hE0); send(8'h75);
        chk("t3_held", 32'(action_held), 32'h14);
        chk("t3_pulse", 32'(action_pulse), 32'h04);
        send(8'hF0); send(8'h29);
        chk("t3_held_after_break", 32'(action_held), 32'h04);
        chk("t3_break_no_pulse", 32'(action_pulse), 32'h0);
        reset_dut();

        send(8'hF0); send(8'hE0);
        chk("t4_seq_error", 32'(seq_error), 32'h1);
        send(8'h1C);
        chk("t4_unknown", 32'(unknown_pulse), 32'h1);
        chk("t4_no_action", 32'(action_pulse), 32'h0);
        chk("t4_last", 32'(last_code), 32'h01C);

        send(8'hE0);
        idle(PT - 1);
        chk("t5_no_early_timeout", 32'(seq_error), 32'h0);
        idle(1);
        chk("t5_timeout", 32'(seq_error), 32'h1);
        send(8'h29);
        chk("t5_pulse", 32'(action_pulse), 32'h10);
        chk("t5_last", 32'(last_code), 32'h029);

        send(8'hF0); send(8'h74);
        chk("brk_not_held", 32'(action_held), 32'h10);
        send(8'hE0); send(8'hE0);
        chk("e0e0_error", 32'(seq_error), 32'h1);
        send(8'h74);
        chk("e0e0_still_ext", 32'(action_pulse), 32'h02);
        send(8'hE0); idle(PT - 2); send(8'hF0); idle(PT - 2); send(8'h74);
        chk("slow_prefix_break", 32'(action_held), 32'h10);
        idle(5);
        reset_dut();

        send(8'h2D);
        chk("t6_press", 32'(action_pulse), 32'h20);
        mask = '0;
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            if (action_pulse[5]) mask[k] = 1'b1;
        end
        chk("t6_repeat_times", mask, 32'h0004_4400);
        wire_reset = 1'b1;
        #1;
        chk("t6_async_rst", {action_pulse, action_held, unknown_pulse, seq_error, last_code}, 32'h0);
        @(posedge clk); #1;
        wire_reset = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
